ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Iterative 32-bit divider in the execute stage, directly downstream of instruction decode.
- Consumes the two decoded operands (rs, rt) for DIV/DIVU and produces {remainder, quotient} for the HI/LO write path.
- Radix-2 restoring division: one quotient bit per cycle.
- The execute stage holds the pipeline stall request high until the result is ready.

Parameters:
- N_DATA, 32, operand width. The quotient and remainder are each N_DATA bits. The iteration count equals N_DATA.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- i_op_0  in  N_DATA  dividend (rs).
- i_op_1  in  N_DATA  divisor (rt).
- i_start  in  1  request division. Held high by the execute stage until o_ready is seen.
- i_annul  in  1  abort the current operation (branch-delay / flush).
- o_result  out  2*N_DATA  {remainder, quotient}: [63:32] = remainder (HI), [31:0] = quotient (LO).
- o_ready  out  1  o_result valid.
- o_busy  out  1  division in progress. Combinational from state.

Behaviour:
- Reset (i_rst_n == 0 at a clock edge):
  - state = IDLE, o_result = 0, o_ready = 0, iteration counter = 0.
  - Reset has priority in every state, so reset mid-operation discards any partial result.
- States: IDLE, DIVZERO, ON, END. o_busy = 1 in ON and DIVZERO, 0 otherwise.
- IDLE:
  - If i_start & !i_annul and i_op_1 == 0: go to DIVZERO.
  - If i_start & !i_annul and i_op_1 != 0: go to ON.
    - Latch the magnitudes |i_op_0| and |i_op_1|, using absolute values only when i_signed = 1.
    - Latch the sign of the dividend, and the XOR of the dividend and divisor signs.
    - Clear the partial remainder and the counter.
  - Otherwise stay in IDLE with o_ready = 0 and o_result = 0.
- ON:
  - Each cycle shift the next dividend bit (MSB first) into the partial remainder. The partial remainder is N_DATA+1 bits wide.
  - Form trial = partial remainder − divisor:
    - if trial ≥ 0: partial remainder = trial, quotient bit = 1;
    - otherwise: partial remainder is unchanged, quotient bit = 0.
  - Counter increments 0..N_DATA-1. On the edge processing iteration N_DATA-1, go to END and register:
    - o_ready = 1;
    - o_result quotient = negated if signed and the signs differ;
    - o_result remainder = negated if signed and the dividend is negative.
  - If i_annul = 1 or i_start = 0 in any ON cycle: go to IDLE next edge, counter cleared, o_ready stays 0.
- DIVZERO: unconditionally go to END next edge with o_result = 0 and o_ready = 1. No exception is raised.
- END:
  - o_ready and o_result are held stable while i_start = 1.
  - When i_start = 0: go to IDLE, with o_ready = 0 and o_result = 0 on the same edge.
  - i_annul is ignored in END.
- Latency:
  - Nonzero divisor: i_start sampled at edge 0; o_ready = 1 after edge N_DATA+1 (33 cycles).
  - Zero divisor: o_ready = 1 after edge 2.
- Arithmetic rules:
  - Quotient truncates toward zero; the remainder sign follows the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - DIVU treats both operands as unsigned; no magnitude conversion.
- Operand capture: operands are sampled only in IDLE. Input changes during ON or END have no effect on the result.
- Back-to-back operations: after END→IDLE, a new i_start is accepted on the following edge at the earliest, because i_start must drop for at least one cycle.

Test Plan:
- Unsigned divide: DIVU, i_op_0 = 100, i_op_1 = 7, hold i_start → o_ready rises exactly 33 edges after start with o_result = {0x00000002, 0x0000000E}. o_busy is high for cycles 1..32.
- Signed signs and min/-1:
  - DIV, −7 / 2 → o_result = {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV, 7 / −2 → {0x00000001, 0xFFFFFFFD}.
  - DIV, 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Divide by zero: DIV, 5 / 0 → DIVZERO then END, o_ready = 1 after 2 edges, o_result = 0. Drop i_start → o_ready = 0 next edge.
- Annul and reset mid-operation:
  - Assert i_annul at ON cycle 10 → IDLE next edge, o_ready never asserts. A following DIVU 9 / 3 returns {0, 3} after 33 edges.
  - Pull i_rst_n low at ON cycle 20 → all outputs 0, state IDLE.
- END hold and operand isolation:
  - Hold i_start high for 5 cycles in END → o_ready and o_result stable throughout.
  - Change i_op_0 and i_op_1 during ON → result unchanged.
  - Drop i_start → IDLE. Restart with a new operand pair → correct result.

Source files
------------

// File: rtl/ex_div_if.sv
// Handshake and operand bundle between the execute stage and the
// iterative divider. The execute stage is the master; the divider is the slave.
interface ex_div_if #(
  parameter int N_DATA = 32
);
  logic                  i_signed;
  logic [N_DATA-1:0]     i_op_0;
  logic [N_DATA-1:0]     i_op_1;
  logic                  i_start;
  logic                  i_annul;
  logic [2*N_DATA-1:0]   o_result;
  logic                  o_ready;
  logic                  o_busy;

  modport master (
    output i_signed, i_op_0, i_op_1, i_start, i_annul,
    input  o_result, o_ready, o_busy
  );

  modport slave (
    input  i_signed, i_op_0, i_op_1, i_start, i_annul,
    output o_result, o_ready, o_busy
  );
endinterface

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} one quotient bit per cycle; the execute
// stage keeps i_start high (and the pipeline stalled) until o_ready.
module ex_div #(
  parameter int N_DATA = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  ex_div_if.slave  bus
);

  localparam int CW = $clog2(N_DATA);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic [N_DATA-1:0]  dvd;       // dividend bits still to consume; quotient bits shift in at the LSB
  logic [N_DATA-1:0]  dvs;       // divisor magnitude
  logic [N_DATA-1:0]  rem;       // partial remainder, always < dvs between iterations
  logic               neg_q;
  logic               neg_r;
  logic [2*N_DATA-1:0] result_q;
  logic               ready_q;

  logic               go;
  logic               abort;
  logic               last;
  logic [N_DATA-1:0]  op0_mag;
  logic [N_DATA-1:0]  op1_mag;
  logic [N_DATA:0]    rem_sh;
  logic [N_DATA:0]    trial;
  logic               q_bit;
  logic [N_DATA-1:0]  rem_next;
  logic [N_DATA-1:0]  quo_next;
  logic [N_DATA-1:0]  q_final;
  logic [N_DATA-1:0]  r_final;

  assign go    = bus.i_start & ~bus.i_annul;
  assign abort = bus.i_annul | ~bus.i_start;
  assign last  = (cnt == CW'(N_DATA - 1));

  // Operand magnitudes; DIVU passes operands through untouched.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    op0_mag = bus.i_op_0;
    op1_mag = bus.i_op_1;
    if (bus.i_signed && bus.i_op_0[N_DATA-1]) op0_mag = -bus.i_op_0;
    if (bus.i_signed && bus.i_op_1[N_DATA-1]) op1_mag = -bus.i_op_1;
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  // The shifted remainder needs N_DATA+1 bits; the difference fits the same
  // width as a signed value because rem_sh < 2*dvs.
  always_comb begin
    rem_sh   = {rem, dvd[N_DATA-1]};
    trial    = rem_sh - {1'b0, dvs};
    q_bit    = ~trial[N_DATA];
    rem_next = q_bit ? trial[N_DATA-1:0] : rem_sh[N_DATA-1:0];
    quo_next = {dvd[N_DATA-2:0], q_bit};
    q_final  = neg_q ? -quo_next : quo_next;
    r_final  = neg_r ? -rem_next : rem_next;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = (bus.i_op_1 == '0) ? DIVZERO : ON;
      ON: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = END;
      end
      DIVZERO: state_next = END;
      END:     if (!bus.i_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.o_busy   = (state == ON) || (state == DIVZERO);
    bus.o_ready  = ready_q;
    bus.o_result = result_q;
  end

  // Datapath: operand capture in IDLE, one iteration per ON cycle.
  always_ff @(posedge i_clk) begin
    // NOTE: datapath registers carry no reset; they are always loaded in IDLE before being used.
    if (state == IDLE && go) begin
      dvd   <= op0_mag;
      dvs   <= op1_mag;
      rem   <= '0;
      neg_r <= bus.i_signed & bus.i_op_0[N_DATA-1];
      neg_q <= bus.i_signed & (bus.i_op_0[N_DATA-1] ^ bus.i_op_1[N_DATA-1]);
    end else if (state == ON) begin
      dvd <= quo_next;
      rem <= rem_next;
    end
  end

  // Iteration counter and registered result/ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt      <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          result_q <= '0;
          ready_q  <= 1'b0;
        end
        ON: begin
          if (abort) begin
            cnt      <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else if (last) begin
            cnt      <= '0;
            result_q <= {r_final, q_final};
            ready_q  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIVZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
        end
        END: begin
          if (!bus.i_start) begin
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: begin
          cnt      <= '0;
          result_q <= '0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table for plain divides plus
// hand-written sequences for annul, reset, END hold and operand isolation.
module tb_ex_div;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ex_div_if #(.N_DATA(N)) bus ();

  ex_div #(.N_DATA(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic          sgn;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [63:0]   exp;
    int            lat;
    string         name;
  } vec_t;

  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an operation at a negedge, hold i_start, count edges until o_ready.
  // Edge count includes the edge that samples i_start.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string name,
                        input bit scramble);
    int n;
    bit busy_ok;
    @(negedge clk);
    bus.i_signed = sgn;
    bus.i_op_0   = a;
    bus.i_op_1   = b;
    bus.i_annul  = 1'b0;
    bus.i_start  = 1'b1;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n == 5) begin
        bus.i_op_0   = $urandom;
        bus.i_op_1   = $urandom;
        bus.i_signed = ~sgn;
      end
      if (!bus.o_ready && !bus.o_busy) busy_ok = 1'b0;
    end while (!bus.o_ready && n < 40);
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " result"}, bus.o_result, exp);
    check({name, " busy while running"}, 64'(busy_ok), 64'd1);
    check({name, " busy in END"}, 64'(bus.o_busy), 64'd0);
  endtask

  // Drop i_start from END; outputs must clear on the next edge.
  task automatic drop_check(input string name);
    bus.i_start = 1'b0;
    @(negedge clk);
    check({name, " ready after drop"}, 64'(bus.o_ready), 64'd0);
    check({name, " result after drop"}, bus.o_result, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit stable;

    vecs[0] = '{1'b0, 32'd100,       32'd7,          {32'h00000002, 32'h0000000E}, 33, "divu 100/7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div -7/2"};
    vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33, "div 7/-2"};
    vecs[3] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33, "div min/-1"};
    vecs[4] = '{1'b1, 32'd5,         32'd0,          64'd0,                        2,  "div 5/0"};
    vecs[5] = '{1'b0, 32'hFFFFFFFF,  32'h00000010,   {32'h0000000F, 32'h0FFFFFFF}, 33, "divu max/16"};
    vecs[6] = '{1'b0, 32'hFFFFFFF9,  32'd2,          {32'h00000001, 32'h7FFFFFFC}, 33, "divu big/2"};
    vecs[7] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 33, "div -100/-7"};
    vecs[8] = '{1'b0, 32'd3,         32'd9,          {32'h00000003, 32'h00000000}, 33, "divu 3/9"};
    vecs[9] = '{1'b0, 32'd0,         32'd0,          64'd0,                        2,  "divu 0/0"};

    bus.i_signed = 1'b0;
    bus.i_op_0   = '0;
    bus.i_op_1   = '0;
    bus.i_start  = 1'b0;
    bus.i_annul  = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ready", 64'(bus.o_ready), 64'd0);
    check("reset result", bus.o_result, 64'd0);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b0);
      drop_check(vecs[i].name);
    end

    // Annul in ON cycle 10 with i_start still high.
    @(negedge clk);
    bus.i_signed = 1'b0;
    bus.i_op_0   = 32'd100;
    bus.i_op_1   = 32'd7;
    bus.i_start  = 1'b1;
    repeat (10) @(negedge clk);
    check("annul busy before", 64'(bus.o_busy), 64'd1);
    bus.i_annul = 1'b1;
    @(negedge clk);
    check("annul busy after", 64'(bus.o_busy), 64'd0);
    seen = bus.o_ready;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_ready || bus.o_busy) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);
    bus.i_annul = 1'b0;
    bus.i_start = 1'b0;
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu 9/3 after annul", 1'b0);
    drop_check("divu 9/3 after annul");

    // Reset in ON cycle 20.
    @(negedge clk);
    bus.i_signed = 1'b0;
    bus.i_op_0   = 32'd100;
    bus.i_op_1   = 32'd7;
    bus.i_start  = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midop reset busy", 64'(bus.o_busy), 64'd0);
    check("midop reset ready", 64'(bus.o_ready), 64'd0);
    check("midop reset result", bus.o_result, 64'd0);
    bus.i_start = 1'b0;
    rst_n = 1'b1;

    // Operand isolation during ON, then hold in END for 5 cycles.
    run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, "isolate 1000/3", 1'b1);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.o_ready || bus.o_result !== {32'd1, 32'd333}) stable = 1'b0;
    end
    check("END hold stable", 64'(stable), 64'd1);
    drop_check("isolate 1000/3");
    run_op(1'b0, 32'd50, 32'd6, {32'd2, 32'd8}, 33, "restart 50/6", 1'b0);
    drop_check("restart 50/6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
